// File: rtl/cluster_packer.sv
// Pixel-stream-to-word packer: gathers 8-bit pixels into 8-pixel words, padding words closed early by i_last.
// Latency: the completing pixel's word is valid the cycle after its accepting edge.
// Backpressure: one completed word can wait behind the output register; o_ready drops only when both are full.
module cluster_packer #(
    parameter int          FIFO_WIDTH = 8,
    parameter logic [7:0]  PAD_VAL    = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pixel,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_pixel_0,
    output logic [7:0] o_pixel_1,
    output logic [7:0] o_pixel_2,
    output logic [7:0] o_pixel_3,
    output logic [7:0] o_pixel_4,
    output logic [7:0] o_pixel_5,
    output logic [7:0] o_pixel_6,
    output logic [7:0] o_pixel_7,
    output logic [3:0] o_count,
    output logic       o_last,
    output logic       o_valid,
    input  logic       i_ready
);

    // The port list is hard-wired to eight pixels, so any other width cannot work.
    generate
        if (FIFO_WIDTH != 8) begin : g_bad_width
            $error("cluster_packer: FIFO_WIDTH must be 8");
        end
    endgenerate

    // FILL: collecting pixels. HOLD: a finished word waits in the fill buffer for the output register.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] fill_q [0:7];
    logic [7:0] fill_d [0:7];
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       hold_last_q, hold_last_d;

    logic [7:0] out_pix_q [0:7];
    logic [7:0] out_pix_d [0:7];
    logic [3:0] out_cnt_q, out_cnt_d;
    logic       out_last_q, out_last_d;
    logic       out_vld_q, out_vld_d;

    logic [7:0] new_word [0:7];
    logic [3:0] new_cnt;
    logic       accept;
    logic       complete;
    logic       drain;
    logic       out_free;

    assign accept   = i_valid && (state_q == FILL);
    assign complete = accept && ((cnt_q == 3'd7) || i_last);
    assign drain    = out_vld_q && i_ready;
    assign out_free = !out_vld_q || i_ready;

    // Word as it would look if closed by the pixel on i_pixel now: earlier slots, this pixel, then padding.
    always_comb begin
        new_cnt = {1'b0, cnt_q} + 4'd1;
        for (int j = 0; j < 8; j++) begin
            new_word[j] = PAD_VAL;
            if (4'(j) < {1'b0, cnt_q}) begin
                new_word[j] = fill_q[j];
            end else if (4'(j) == {1'b0, cnt_q}) begin
                new_word[j] = i_pixel;
            end
        end
    end

    // Next-state and datapath: fill, complete into the output register or park in HOLD, release on drain.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        hold_cnt_d  = hold_cnt_q;
        hold_last_d = hold_last_q;
        out_pix_d   = out_pix_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;

        // A draining word leaves; it is only replaced if a new one loads below.
        if (drain) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        if (out_free) begin
                            out_pix_d  = new_word;
                            out_cnt_d  = new_cnt;
                            out_last_d = i_last;
                            out_vld_d  = 1'b1;
                            cnt_d      = 3'd0;
                        end else begin
                            // Freeze the padded word in the fill buffer until the output frees up.
                            fill_d      = new_word;
                            hold_cnt_d  = new_cnt;
                            hold_last_d = i_last;
                            state_d     = HOLD;
                        end
                    end else begin
                        fill_d[cnt_q] = i_pixel;
                        cnt_d         = cnt_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    out_pix_d  = fill_q;
                    out_cnt_d  = hold_cnt_q;
                    out_last_d = hold_last_q;
                    out_vld_d  = 1'b1;
                    cnt_d      = 3'd0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill buffer, held-word descriptor and output register; reset discards any partial word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= 3'd0;
            hold_cnt_q  <= 4'd0;
            hold_last_q <= 1'b0;
            out_cnt_q   <= 4'd0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                fill_q[j]    <= 8'h00;
                out_pix_q[j] <= 8'h00;
            end
        end else begin
            cnt_q       <= cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_last_q <= hold_last_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
            for (int j = 0; j < 8; j++) begin
                fill_q[j]    <= fill_d[j];
                out_pix_q[j] <= out_pix_d[j];
            end
        end
    end

    assign o_ready   = (state_q == FILL);
    assign o_valid   = out_vld_q;
    assign o_count   = out_cnt_q;
    assign o_last    = out_last_q;
    assign o_pixel_0 = out_pix_q[0];
    assign o_pixel_1 = out_pix_q[1];
    assign o_pixel_2 = out_pix_q[2];
    assign o_pixel_3 = out_pix_q[3];
    assign o_pixel_4 = out_pix_q[4];
    assign o_pixel_5 = out_pix_q[5];
    assign o_pixel_6 = out_pix_q[6];
    assign o_pixel_7 = out_pix_q[7];

endmodule

// File: tb/tb_cluster_packer.sv
// Directed bench for cluster_packer with a word scoreboard.
// Expected words are built from accepted pixels and compared as the DUT hands them off.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_cluster_packer;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_pixel;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [7:0] o_pixel_0, o_pixel_1, o_pixel_2, o_pixel_3;
    logic [7:0] o_pixel_4, o_pixel_5, o_pixel_6, o_pixel_7;
    logic [3:0] o_count;
    logic       o_last;
    logic       o_valid;
    logic       i_ready;

    cluster_packer #(.FIFO_WIDTH(8), .PAD_VAL(8'h00)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pixel   (i_pixel),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .o_pixel_0 (o_pixel_0),
        .o_pixel_1 (o_pixel_1),
        .o_pixel_2 (o_pixel_2),
        .o_pixel_3 (o_pixel_3),
        .o_pixel_4 (o_pixel_4),
        .o_pixel_5 (o_pixel_5),
        .o_pixel_6 (o_pixel_6),
        .o_pixel_7 (o_pixel_7),
        .o_count   (o_count),
        .o_last    (o_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] pix;
        logic [3:0]  cnt;
        logic        last;
    } word_t;

    word_t       exp_q [$];
    logic [63:0] cur_pix;
    int          cur_n;
    int          checks;
    int          errors;
    int          vld_cnt;
    int          nacc;
    int          ready_drops;
    logic        stall_prev;
    logic [63:0] stall_pix;
    logic [3:0]  stall_cnt;
    logic        stall_last;

    function automatic logic [63:0] obs_word();
        return {o_pixel_7, o_pixel_6, o_pixel_5, o_pixel_4,
                o_pixel_3, o_pixel_2, o_pixel_1, o_pixel_0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_pix = '0;
        cur_n   = 0;
    endtask

    // Falling-edge observation: handoff check, stall stability, then record the pixel about to be taken.
    task automatic mon();
        word_t w;
        if (o_valid) vld_cnt++;
        if (stall_prev && o_valid) begin
            chk("stall_pix", obs_word(), stall_pix);
            chk("stall_cnt", 64'(o_count), 64'(stall_cnt));
            chk("stall_last", 64'(o_last), 64'(stall_last));
        end
        stall_prev = o_valid && !i_ready;
        stall_pix  = obs_word();
        stall_cnt  = o_count;
        stall_last = o_last;
        if (o_valid && i_ready) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("word_pix", obs_word(), w.pix);
                chk("word_cnt", 64'(o_count), 64'(w.cnt));
                chk("word_last", 64'(o_last), 64'(w.last));
            end
        end
        if (i_valid && o_ready) begin
            cur_pix[8*cur_n +: 8] = i_pixel;
            cur_n++;
            if (cur_n == 8 || i_last) begin
                w.pix  = cur_pix;
                w.cnt  = 4'(cur_n);
                w.last = i_last;
                exp_q.push_back(w);
                cur_pix = '0;
                cur_n   = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] p, input logic l, input logic r);
        i_valid = v;
        i_pixel = p;
        i_last  = l;
        i_ready = r;
        @(negedge i_clk);
        mon();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; vld_cnt = 0; stall_prev = 1'b0;
        stall_pix = '0; stall_cnt = '0; stall_last = 1'b0;
        model_clear();
        i_rst = 1'b1; i_valid = 1'b0; i_pixel = 8'h00; i_last = 1'b0; i_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_pix", obs_word(), 64'd0);
        chk("rst_cnt", 64'(o_count), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Basic pack
        vld_cnt = 0; ready_drops = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(i + 1), 1'b0, 1'b1);
            if (!o_ready) ready_drops++;
        end
        chk("basic_latency", 64'(o_valid), 64'd1);
        chk("basic_word", obs_word(), 64'h0807060504030201);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("basic_vld_once", 64'(vld_cnt), 64'd1);
        chk("basic_ready", 64'(ready_drops), 64'd0);

        // Early close, then a full word starting at slot 0
        cycle(1'b1, 8'hA1, 1'b0, 1'b1);
        cycle(1'b1, 8'hA2, 1'b0, 1'b1);
        cycle(1'b1, 8'hA3, 1'b1, 1'b1);
        chk("early_word", obs_word(), 64'h0000000000A3A2A1);
        chk("early_cnt", 64'(o_count), 64'd3);
        chk("early_last", 64'(o_last), 64'd1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0, 1'b1);
        chk("after_early_word", obs_word(), 64'h3837363534333231);
        // Early close on the 8th pixel: one word, count 8, last set
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h41 + i), (i == 7), 1'b1);
        chk("last8_cnt", 64'(o_count), 64'd8);
        chk("last8_last", 64'(o_last), 64'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("last8_no_extra", 64'(o_valid), 64'd0);

        // Backpressure: two words absorbed, then o_ready falls
        nacc = 0;
        for (int i = 0; i < 17; i++) begin
            logic ok;
            ok = o_ready;
            cycle(1'b1, 8'(8'h10 + nacc), 1'b0, 1'b0);
            if (ok) nacc++;
        end
        chk("bp_accepted", 64'(nacc), 64'd16);
        chk("bp_ready_low", 64'(o_ready), 64'd0);
        chk("bp_first_held", obs_word(), 64'h1716151413121110);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("bp_ready_back", 64'(o_ready), 64'd1);
        chk("bp_second_valid", 64'(o_valid), 64'd1);
        chk("bp_second_word", obs_word(), 64'h1F1E1D1C1B1A1918);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Same-edge completion and drain
        vld_cnt = 0; ready_drops = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
            if (!o_ready) ready_drops++;
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stream_ready", 64'(ready_drops), 64'd0);
        chk("stream_words", 64'(vld_cnt), 64'd3);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-word with a stalled word on the outputs
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        i_valid = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_pix", obs_word(), 64'd0);
        chk("mid_rst_cnt", 64'(o_count), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        #1 i_rst = 1'b0;
        model_clear();
        stall_prev = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b1);
        chk("post_rst_word", obs_word(), 64'h2827262524232221);
        chk("post_rst_cnt", 64'(o_count), 64'd8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Round trip pattern
        cycle(1'b1, 8'hB3, 1'b0, 1'b0);
        cycle(1'b1, 8'h50, 1'b0, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0);
        cycle(1'b1, 8'hBE, 1'b0, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0, 1'b0);
        cycle(1'b1, 8'h50, 1'b0, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0);
        cycle(1'b1, 8'hBE, 1'b0, 1'b0);
        chk("roundtrip_word", obs_word(), 64'hBEEF50B3BEEF50B3);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_partial", 64'(cur_n), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
